control_unit: RTL and testbench

- Hardwired Mini-SRC control sequencer that drives every control input of the phase-2 datapath. It takes IR and CON FF state from the datapath.
- Runs the fetch (T0–T2) and execute (T3–T7) steps for all 28 opcodes, handles halt and stop, and counts retired instructions.
- The datapath derives the ALU op and register selects from IR. This block supplies only step timing.

---
 rtl/control_unit.sv | 170 +++++++++++++++++
 tb/tb_control_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Hardwired Mini-SRC control sequencer: fetch T0-T2, execute T3-T7, halt/stop handling
// and a retired-instruction counter. All control outputs are a combinational decode of state, opcode and CON.
module control_unit #(
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      ir,
    input  logic             con_out,
    input  logic             stop,
    output logic             pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out,
    output logic             c_sign_extended_out,
    output logic             mar_enable, z_enable, pc_enable, mdr_enable, ir_enable, y_enable,
    output logic             hi_enable, lo_enable, r15_enable, outport_enable, con_enable,
    output logic             read, ram_write, pc_increment,
    output logic             gra, grb, grc, r_in, r_out, ba_out,
    output logic             run,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

    state_t           state_q, state_d;
    logic [2:0]       wait_q, wait_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [4:0] op;
    logic       ir_unused;
    logic       is_ralu, is_ialu, is_ld, is_ldi, is_st, is_negnot, is_muldiv, is_br, is_jr, is_jal;
    logic       is_in, is_out, is_mfhi, is_mflo, is_halt, is_undef;
    logic [2:0] last_step;
    state_t     entry_state;

    assign op        = ir[31:27];
    assign ir_unused = ^ir[26:0];

    assign is_ralu   = (op >= 5'd3) && (op <= 5'd11);
    assign is_ialu   = (op >= 5'd12) && (op <= 5'd14);
    assign is_ld     = (op == 5'd0);
    assign is_ldi    = (op == 5'd1);
    assign is_st     = (op == 5'd2);
    assign is_muldiv = (op == 5'd15) || (op == 5'd16);
    assign is_negnot = (op == 5'd17) || (op == 5'd18);
    assign is_br     = (op == 5'd19);
    assign is_jr     = (op == 5'd20);
    assign is_jal    = (op == 5'd21);
    assign is_in     = (op == 5'd22);
    assign is_out    = (op == 5'd23);
    assign is_mfhi   = (op == 5'd24);
    assign is_mflo   = (op == 5'd25);
    assign is_halt   = (op == 5'd27);
    assign is_undef  = (op >= 5'd28);

    // Final execute step per opcode; everything not listed (jr, in, out, mf*, nop, undefined) ends at T3.
    always_comb begin
        last_step = 3'd3;
        if (is_ld || is_st)                      last_step = 3'd7;
        else if (is_muldiv || is_br)             last_step = 3'd6;
        else if (is_ralu || is_ialu || is_ldi)   last_step = 3'd5;
        else if (is_negnot || is_jal)            last_step = 3'd4;
    end

    // stop is only honoured on the way into T0, so an instruction in flight always completes.
    assign entry_state = stop ? S_HALT : S_T0;

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        count_d = count_q;
        case (state_q)
            S_RESET: state_d = entry_state;
            S_T0:    state_d = S_T1;
            S_T1: begin
                if (wait_q == WAIT_LAST) state_d = S_T2;
                else                     wait_d  = wait_q + 3'd1;
            end
            S_T2: begin
                state_d = S_T3;
                count_d = count_q + 1'b1;
            end
            S_T3: begin
                if (is_halt)                 state_d = S_HALT;
                else if (last_step == 3'd3)  state_d = entry_state;
                else                         state_d = S_T4;
            end
            S_T4:    state_d = (last_step == 3'd4) ? entry_state : S_T5;
            S_T5:    state_d = (last_step == 3'd5) ? entry_state : S_T6;
            S_T6: begin
                if (is_ld && (wait_q != WAIT_LAST)) wait_d  = wait_q + 3'd1;
                else if (last_step == 3'd6)         state_d = entry_state;
                else                                state_d = S_T7;
            end
            S_T7:    state_d = entry_state;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_RESET;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
        end
    end

    assign instr_count = count_q;

    always_comb begin
        {pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out, c_sign_extended_out} = '0;
        {mar_enable, z_enable, pc_enable, mdr_enable, ir_enable, y_enable} = '0;
        {hi_enable, lo_enable, r15_enable, outport_enable, con_enable} = '0;
        {read, ram_write, pc_increment, gra, grb, grc, r_in, r_out, ba_out} = '0;
        illegal_op = 1'b0;
        run        = (state_q != S_RESET) && (state_q != S_HALT);
        case (state_q)
            S_T0: begin pc_out = 1'b1; mar_enable = 1'b1; pc_increment = 1'b1; end
            S_T1: begin read = 1'b1; mdr_enable = 1'b1; end
            S_T2: begin mdr_out = 1'b1; ir_enable = 1'b1; end
            S_T3: begin
                if (is_ralu || is_ialu)          begin grb = 1'b1; r_out = 1'b1; y_enable = 1'b1; end
                if (is_ld || is_ldi || is_st)    begin grb = 1'b1; ba_out = 1'b1; y_enable = 1'b1; end
                if (is_negnot)                   begin grb = 1'b1; r_out = 1'b1; z_enable = 1'b1; end
                if (is_muldiv)                   begin gra = 1'b1; r_out = 1'b1; y_enable = 1'b1; end
                if (is_br)                       begin gra = 1'b1; r_out = 1'b1; con_enable = 1'b1; end
                if (is_jr)                       begin gra = 1'b1; r_out = 1'b1; pc_enable = 1'b1; end
                if (is_jal)                      begin pc_out = 1'b1; r15_enable = 1'b1; end
                if (is_in)                       begin inport_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                if (is_out)                      begin gra = 1'b1; r_out = 1'b1; outport_enable = 1'b1; end
                if (is_mfhi)                     begin hi_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                if (is_mflo)                     begin lo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                illegal_op = is_undef;
            end
            S_T4: begin
                if (is_ralu)                     begin grc = 1'b1; r_out = 1'b1; z_enable = 1'b1; end
                if (is_ialu || is_ld || is_ldi || is_st) begin c_sign_extended_out = 1'b1; z_enable = 1'b1; end
                if (is_negnot)                   begin zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                if (is_muldiv)                   begin grb = 1'b1; r_out = 1'b1; z_enable = 1'b1; end
                if (is_br)                       begin pc_out = 1'b1; y_enable = 1'b1; end
                if (is_jal)                      begin gra = 1'b1; r_out = 1'b1; pc_enable = 1'b1; end
            end
            S_T5: begin
                if (is_ralu || is_ialu || is_ldi) begin zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                if (is_ld || is_st)              begin zlo_out = 1'b1; mar_enable = 1'b1; end
                if (is_muldiv)                   begin zlo_out = 1'b1; lo_enable = 1'b1; end
                if (is_br)                       begin c_sign_extended_out = 1'b1; z_enable = 1'b1; end
            end
            S_T6: begin
                if (is_ld)                       begin read = 1'b1; mdr_enable = 1'b1; end
                if (is_st)                       begin gra = 1'b1; r_out = 1'b1; mdr_enable = 1'b1; end
                if (is_muldiv)                   begin zhi_out = 1'b1; hi_enable = 1'b1; end
                if (is_br)                       begin zlo_out = 1'b1; pc_enable = con_out; end
            end
            S_T7: begin
                if (is_ld)                       begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                if (is_st)                       ram_write = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// Scoreboarded bench for control_unit: one instance with MEM_WAIT=1, one with MEM_WAIT=3 and a 3-bit counter.
module tb_control_unit;
    logic        clk;
    logic        clr1, clr3, con_r, stop, sel;
    logic [31:0] ir;
    wire  [29:0] c1, c3;
    wire  [31:0] n1;
    wire  [2:0]  n3;
    wire  [29:0] cv = sel ? c3 : c1;
    wire  [31:0] cc = sel ? {29'd0, n3} : n1;

    // Bit positions inside the captured control vector.
    localparam int PC_OUT = 0, ZLO = 1, ZHI = 2, MAR = 8, PC_EN = 10, MDR_EN = 11;
    localparam int HI_EN = 14, LO_EN = 15, RD = 19, WR = 20, PC_INC = 21, GRA = 22, R_IN = 25;
    localparam int RUN = 28, ILL = 29;
    localparam logic [29:0] T0_VEC = (30'd1 << PC_OUT) | (30'd1 << MAR) | (30'd1 << PC_INC) | (30'd1 << RUN);

    typedef struct { int cyc; int cnt; } exp_t;
    exp_t        sb[$];
    logic [29:0] tr [0:39];
    int          n_total = 0, n_bad = 0, ncyc, cnt1 = 0, cnt3 = 0;

    control_unit #(.MEM_WAIT(1), .CNT_W(32)) u1 (
        .clk(clk), .clr(clr1), .ir(ir), .con_out(con_r), .stop(stop),
        .pc_out(c1[0]), .zlo_out(c1[1]), .zhi_out(c1[2]), .hi_out(c1[3]), .lo_out(c1[4]),
        .mdr_out(c1[5]), .inport_out(c1[6]), .c_sign_extended_out(c1[7]),
        .mar_enable(c1[8]), .z_enable(c1[9]), .pc_enable(c1[10]), .mdr_enable(c1[11]),
        .ir_enable(c1[12]), .y_enable(c1[13]), .hi_enable(c1[14]), .lo_enable(c1[15]),
        .r15_enable(c1[16]), .outport_enable(c1[17]), .con_enable(c1[18]),
        .read(c1[19]), .ram_write(c1[20]), .pc_increment(c1[21]),
        .gra(c1[22]), .grb(c1[23]), .grc(c1[24]), .r_in(c1[25]), .r_out(c1[26]), .ba_out(c1[27]),
        .run(c1[28]), .illegal_op(c1[29]), .instr_count(n1)
    );

    control_unit #(.MEM_WAIT(3), .CNT_W(3)) u3 (
        .clk(clk), .clr(clr3), .ir(ir), .con_out(con_r), .stop(stop),
        .pc_out(c3[0]), .zlo_out(c3[1]), .zhi_out(c3[2]), .hi_out(c3[3]), .lo_out(c3[4]),
        .mdr_out(c3[5]), .inport_out(c3[6]), .c_sign_extended_out(c3[7]),
        .mar_enable(c3[8]), .z_enable(c3[9]), .pc_enable(c3[10]), .mdr_enable(c3[11]),
        .ir_enable(c3[12]), .y_enable(c3[13]), .hi_enable(c3[14]), .lo_enable(c3[15]),
        .r15_enable(c3[16]), .outport_enable(c3[17]), .con_enable(c3[18]),
        .read(c3[19]), .ram_write(c3[20]), .pc_increment(c3[21]),
        .gra(c3[22]), .grb(c3[23]), .grc(c3[24]), .r_in(c3[25]), .r_out(c3[26]), .ba_out(c3[27]),
        .run(c3[28]), .illegal_op(c3[29]), .instr_count(n3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drives one instruction from a T0 sample and records one control vector per cycle until
    // the next T0, loss of run, or the cycle budget.
    task automatic run_instr(input string tag, input logic [4:0] op, input logic c,
                             input int exp_cyc, input int stop_at);
        exp_t e;
        int   n;
        ir    = {op, 27'd0};
        con_r = c;
        if (sel) cnt3 = (cnt3 + 1) % 8;
        else     cnt1 = cnt1 + 1;
        e.cyc = exp_cyc;
        e.cnt = sel ? cnt3 : cnt1;
        sb.push_back(e);
        n = 0;
        do begin
            tr[n] = cv;
            n++;
            if (n == stop_at) stop = 1'b1;
            @(negedge clk);
        end while (cv[PC_INC] == 1'b0 && cv[RUN] == 1'b1 && n < 40);
        ncyc = n;
        e = sb.pop_front();
        check({tag, ".cycles"}, n, e.cyc);
        check({tag, ".count"}, cc, e.cnt);
    endtask

    initial begin
        int k, rd, wr;
        clr1 = 1'b0; clr3 = 1'b0; stop = 1'b0; con_r = 1'b0; sel = 1'b0; ir = '0;
        repeat (2) @(negedge clk);
        check("reset.outs", cv, 0);
        check("reset.count", cc, 0);
        clr1 = 1'b1;
        @(negedge clk);
        check("reset.t0", cv, T0_VEC);

        run_instr("add", 5'b00011, 1'b0, 6, 0);
        check("add.t5", tr[5], (30'd1 << ZLO) | (30'd1 << GRA) | (30'd1 << R_IN) | (30'd1 << RUN));

        run_instr("br0", 5'b10011, 1'b0, 7, 0);
        check("br0.t6_pcen", tr[6][PC_EN], 0);
        check("br0.t6_zlo", tr[6][ZLO], 1);
        run_instr("br1", 5'b10011, 1'b1, 7, 0);
        check("br1.t6_pcen", tr[6][PC_EN], 1);

        run_instr("mul", 5'b10000, 1'b0, 7, 0);
        check("mul.t5_lo", tr[5][LO_EN], 1);
        check("mul.t6_hi", tr[6][HI_EN], 1);
        k = 0;
        for (int i = 0; i < ncyc; i++) if (tr[i][LO_EN] && tr[i][HI_EN]) k++;
        check("mul.both", k, 0);

        run_instr("illegal", 5'b11111, 1'b0, 4, 0);
        k = 0;
        for (int i = 0; i < ncyc; i++) if (tr[i][ILL]) k++;
        check("illegal.pulses", k, 1);
        check("illegal.t3", tr[3][ILL], 1);
        check("illegal.next_t0", cv, T0_VEC);

        run_instr("add_stop", 5'b00011, 1'b0, 6, 2);
        check("add_stop.t5", tr[5][R_IN], 1);
        check("add_stop.halted", cv, 0);

        clr1 = 1'b0; stop = 1'b0; cnt1 = 0;
        @(negedge clk);
        clr1 = 1'b1;
        @(negedge clk);
        run_instr("halt", 5'b11011, 1'b0, 4, 0);
        check("halt.outs", cv, 0);
        k = 0;
        repeat (20) begin
            @(negedge clk);
            if (cv != 30'd0) k++;
        end
        check("halt.frozen", k, 0);

        clr1 = 1'b0; sel = 1'b1; clr3 = 1'b1;
        @(negedge clk);
        check("u3.t0", cv, T0_VEC);
        run_instr("st", 5'b00010, 1'b0, 10, 0);
        rd = 0; wr = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (tr[i][RD]) rd++;
            if (tr[i][WR]) wr++;
        end
        check("st.reads", rd, 3);
        check("st.t1_read", {tr[1][RD], tr[2][RD], tr[3][RD]}, 3'b111);
        check("st.t6", {tr[8][RD], tr[8][MDR_EN]}, 2'b01);
        check("st.writes", wr, 1);
        check("st.t7_write", tr[9][WR], 1);

        // ld aborted by reset in T6 (first T6 cycle sits 8 cycles after T0 with MEM_WAIT=3).
        ir = {5'b00000, 27'd0};
        wr = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cv[WR]) wr++;
        end
        check("ld.t6_read", cv[RD], 1);
        clr3 = 1'b0;
        #1;
        check("ld_rst.outs", cv, 0);
        check("ld_rst.count", cc, 0);
        cnt3 = 0;
        @(negedge clk);
        clr3 = 1'b1;
        @(negedge clk);
        if (cv[WR]) wr++;
        check("ld_rst.t0", cv, T0_VEC);
        check("ld_rst.no_write", wr, 0);

        for (int i = 0; i < 8; i++) run_instr("nop_wrap", 5'b11010, 1'b0, 6, 0);
        check("wrap.count", cc, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
